// File: rtl/bw_clk_pkg.sv
// Shared types for the cluster clock-stop controller.
// FSM state encoding and stop-counter saturation limit.
package bw_clk_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    DRAIN   = 2'b01,
    STOPPED = 2'b10,
    RESTART = 2'b11
  } bw_clk_state_e;

  localparam logic [7:0] BW_CLK_STOP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/bw_clk_stop_sync.sv
// Multi-flop synchronizer for the asynchronous stop request.
// Synchronous active-low reset clears every stage.
module bw_clk_stop_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_l,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_l) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/bw_clk_cclk_stop_ctl.sv
// Leaf-end clock-stop controller with four-phase stop handshake.
// Optional completed-stop counter enabled by BW_CLK_STOP_CNT_EN.
module bw_clk_cclk_stop_ctl
  import bw_clk_pkg::*;
#(
  parameter int DLY_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             gclk,
  input  logic             grst_l,
  input  logic             stop_req,
  input  logic [DLY_W-1:0] stop_dly,
  input  logic             se,
  output logic             clk_en,
  output logic             stop_ack
`ifdef BW_CLK_STOP_CNT_EN
  ,
  output logic [7:0]       stop_cnt
`endif
);

  bw_clk_state_e    state;
  logic             req_s;
  logic             en_q;
  logic [DLY_W-1:0] cnt;

  bw_clk_stop_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (gclk),
    .rst_l(grst_l),
    .d    (stop_req),
    .q    (req_s)
  );

  always_ff @(posedge gclk) begin
    if (!grst_l) begin
      state    <= RUN;
      en_q     <= 1'b1;
      stop_ack <= 1'b0;
      cnt      <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (req_s) begin
            if (stop_dly == '0) begin
              state    <= STOPPED;
              en_q     <= 1'b0;
              stop_ack <= 1'b1;
            end else begin
              state <= DRAIN;
              cnt   <= stop_dly;
            end
          end
        end
        DRAIN: begin
          if (!req_s) begin
            state <= RUN;
            cnt   <= '0;
          end else if (cnt == DLY_W'(1)) begin
            state    <= STOPPED;
            en_q     <= 1'b0;
            stop_ack <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt - DLY_W'(1);
          end
        end
        STOPPED: begin
          if (!req_s) begin
            state <= RESTART;
            en_q  <= 1'b1;
          end
        end
        RESTART: begin
          // ack holds one cycle after the clock resumes
          state    <= RUN;
          stop_ack <= 1'b0;
        end
      endcase
    end
  end

  assign clk_en = en_q | se;

`ifdef BW_CLK_STOP_CNT_EN
  logic [7:0] stop_cnt_q;

  always_ff @(posedge gclk) begin
    if (!grst_l) begin
      stop_cnt_q <= '0;
    end else if (state == STOPPED && !req_s
                 && stop_cnt_q != BW_CLK_STOP_CNT_MAX) begin
      stop_cnt_q <= stop_cnt_q + 8'd1;
    end
  end

  assign stop_cnt = stop_cnt_q;
`endif

endmodule

// File: doc/bw_clk_cclk_stop_ctl.md
# bw_clk_cclk_stop_ctl

Leaf-end clock-stop controller for a cluster clock header. The global clock tree delivers `gclk` to the cluster through inverter stages. This block sits at the receiving end of that tree and of the stop/start request path from the clock control unit. It synchronizes the stop request, drains a programmable number of cycles, deasserts the cluster clock enable, and acknowledges with a four-phase handshake. On release it restarts the clock and completes the handshake.

## Interface
Parameters:
- `DLY_W`, default 4: width of the stop-drain delay field.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `stop_req`. Legal values are 2 or 3.

Ports:
- `gclk`, input, 1: global clock, the only clock.
- `grst_l`, input, 1: reset, synchronous, active-low.
- `stop_req`, input, 1: level stop request from the clock control unit. Asynchronous relative to the local tree.
- `stop_dly`, input, `DLY_W`: drain cycles between recognizing a request and gating. Sampled once, when the request is recognized.
- `se`, input, 1: scan enable. Forces the clock on.
- `clk_en`, output, 1: enable to the downstream latch-based clock gate.
- `stop_ack`, output, 1: stop acknowledge.
- `stop_cnt`, output, 8: count of completed stops. Present only with the `BW_CLK_STOP_CNT_EN` macro (see Configuration).

## Operation
- `req_s` is the output of the last synchronizer stage.
- `clk_en` = `en_q | se`, where `en_q` is a registered output. `se` never affects state, counter or ack.
- The FSM has four states: RUN, DRAIN, STOPPED, RESTART.
- RUN: `en_q`=1, `stop_ack`=0.
  - `req_s`=1 and `stop_dly`=0: go to STOPPED.
  - `req_s`=1 and `stop_dly`≠0: go to DRAIN, with `cnt` loaded from `stop_dly`.
- DRAIN: `en_q`=1, `stop_ack`=0.
  - `req_s`=0: go to RUN. This is an abort; `cnt` clears and no ack is ever raised.
  - `cnt`==1: go to STOPPED.
  - Otherwise `cnt` decrements.
- STOPPED: `en_q`=0, `stop_ack`=1.
  - `req_s`=0: go to RESTART.
- RESTART: `en_q`=1, `stop_ack`=1 for exactly one cycle, then go to RUN unconditionally.
  - A `req_s` that is 1 again in RESTART is recognized from RUN on the next cycle.
- Handshake: `stop_ack` rises only after the clock is gated. It falls only after the clock has run at least one cycle.
- `cnt` is `DLY_W` bits wide with no wrap. The largest `stop_dly` is 2^`DLY_W`−1.
- A change to `stop_dly` during DRAIN has no effect.
- Reset (`grst_l`=0 at a `gclk` edge) gives:
  - state RUN, `en_q`=1, so `clk_en`=1: clocks run during reset;
  - `stop_ack`=0, `cnt`=0, synchronizer flops 0, `stop_cnt`=0.
- Reset mid-operation in any state returns to these values on the next edge. The stop in progress is abandoned and not counted.

## Timing
- All state changes happen on the rising edge of `gclk`.
- Raw `stop_req` rises before edge E. Then `req_s`=1 from edge E+`SYNC_STAGES`−1, called cycle T.
- With `stop_dly`=N:
  - `en_q`=0 and `stop_ack`=1 from cycle T+1+N.
  - Total latency from raw request to gating is `SYNC_STAGES`+N cycles.
- Release: `req_s` falls in cycle U while STOPPED. Then:
  - `en_q`=1 from cycle U+1 (RESTART);
  - `stop_ack`=0 from cycle U+2.
- `clk_en` and `stop_ack` come straight from flops, except for the `se` OR. The two are glitch-free relative to `gclk`.

## Configuration
- With `BW_CLK_STOP_CNT_EN` defined:
  - the `stop_cnt` port exists;
  - it increments by 1 on each STOPPED→RESTART transition, saturating at 255;
  - it clears on reset.
- Without the macro there is no port and no counter logic. FSM behaviour is identical either way.

## Structure
- Shared package `bw_clk_pkg` holds:
  - the state enum (RUN=2'b00, DRAIN=2'b01, STOPPED=2'b10, RESTART=2'b11);
  - `BW_CLK_STOP_CNT_MAX`=8'hFF.
- One sub-module, `bw_clk_stop_sync`: a `SYNC_STAGES`-deep synchronizer with synchronous active-low reset, instanced once for `stop_req`.

## Test plan
- **Basic stop/start.** Reset, `SYNC_STAGES`=2, `stop_dly`=3. Raise `stop_req`.
  - `clk_en` falls and `stop_ack` rises exactly 5 edges later.
  - After `stop_req` is dropped, `clk_en`=1 at U+1 and `stop_ack`=0 at U+2.
- **Zero delay.** `stop_dly`=0.
  - Gating and ack occur `SYNC_STAGES` edges after the raw request.
  - The FSM never visits DRAIN.
- **Abort.** `stop_dly`=10, then drop `stop_req` once `req_s` has been 1 for 4 cycles.
  - FSM returns to RUN.
  - `stop_ack` stays 0 throughout, `clk_en` stays 1 throughout.
  - `stop_cnt` is unchanged.
- **Scan override.** `se`=1 while STOPPED.
  - `clk_en`=1 the same cycle.
  - `stop_ack` stays 1 and the state stays STOPPED.
  - `se`=0 returns `clk_en` to 0.
- **Reset mid-stop.** `grst_l`=0 in DRAIN and in STOPPED.
  - Next edge: `clk_en`=1, `stop_ack`=0, state RUN, `stop_cnt` unchanged by the aborted stop.
- **Counter saturation (macro defined).** Run 257 complete stop/start cycles.
  - `stop_cnt` reads 255.
